// File: rtl/step_pkg.sv
// Speed-code values shared with the speed selector, coil phase patterns and period math.
package step_pkg;

  localparam logic [2:0] SPD_10 = 3'b001;
  localparam logic [2:0] SPD_20 = 3'b010;
  localparam logic [2:0] SPD_30 = 3'b011;
  localparam logic [2:0] SPD_40 = 3'b100;
  localparam logic [2:0] SPD_50 = 3'b101;
  localparam logic [2:0] SPD_60 = 3'b110;

  localparam logic [3:0] PH0 = 4'b0011;
  localparam logic [3:0] PH1 = 4'b0110;
  localparam logic [3:0] PH2 = 4'b1100;
  localparam logic [3:0] PH3 = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic spd_valid(input logic [2:0] code);
    return (code >= SPD_10) && (code <= SPD_60);
  endfunction

  function automatic logic [3:0] phase_pat(input logic [1:0] ph);
    logic [3:0] pat;
    case (ph)
      2'd0:    pat = PH0;
      2'd1:    pat = PH1;
      2'd2:    pat = PH2;
      default: pat = PH3;
    endcase
    return pat;
  endfunction

  // Clock cycles per full step for rpm code 1..6; callers must not pass 0 or 7.
  function automatic longint calc_period(input int clk_hz, input int steps_per_rev, input int code);
    longint num;
    longint den;
    longint per;
    num = longint'(clk_hz) * longint'(60);
    den = longint'(code) * longint'(10) * longint'(steps_per_rev);
    per = num / den;
    if (per < longint'(2)) per = longint'(2);
    return per;
  endfunction

endpackage

// File: rtl/step_period_lut.sv
// Maps an rpm code to its step period in clock cycles; purely combinational, zero latency.
// Invalid codes return 0 and are never loaded by the sequencer.
module step_period_lut
  import step_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int STEPS_PER_REV = 200,
  parameter int CNT_W         = 24
) (
  input  logic [2:0]       code,
  output logic [CNT_W-1:0] period
);

  localparam longint P1 = calc_period(CLK_HZ, STEPS_PER_REV, 1);
  localparam longint P2 = calc_period(CLK_HZ, STEPS_PER_REV, 2);
  localparam longint P3 = calc_period(CLK_HZ, STEPS_PER_REV, 3);
  localparam longint P4 = calc_period(CLK_HZ, STEPS_PER_REV, 4);
  localparam longint P5 = calc_period(CLK_HZ, STEPS_PER_REV, 5);
  localparam longint P6 = calc_period(CLK_HZ, STEPS_PER_REV, 6);
  localparam longint CNT_LIM = longint'(1) << CNT_W;

  // The slowest code has the longest period, so it alone bounds the counter width.
  if (P1 >= CNT_LIM) begin : g_cnt_w_check
    $error("step_period_lut: CNT_W too narrow for the code-1 step period");
  end

  always_comb begin
    period = '0;
    case (code)
      SPD_10:  period = CNT_W'(P1);
      SPD_20:  period = CNT_W'(P2);
      SPD_30:  period = CNT_W'(P3);
      SPD_40:  period = CNT_W'(P4);
      SPD_50:  period = CNT_W'(P5);
      SPD_60:  period = CNT_W'(P6);
      default: period = '0;
    endcase
  end

endmodule

// File: rtl/step_sequencer.sv
// Full-step 4-phase stepper sequencer driven by a 3-bit rpm code; speed/dir apply on step boundaries.
// First step_tick lands per_q cycles after entering RUN; en=0 de-energises on the next edge.
module step_sequencer
  import step_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int STEPS_PER_REV = 200,
  parameter int CNT_W         = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic [2:0] speed_in,
  output logic [3:0] coil_out,
  output logic       step_tick,
  output logic       running
);

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [1:0]       phase_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [3:0]       coil_q, coil_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] lut_per;

  step_period_lut #(
    .CLK_HZ       (CLK_HZ),
    .STEPS_PER_REV(STEPS_PER_REV),
    .CNT_W        (CNT_W)
  ) u_lut (
    .code  (speed_in),
    .period(lut_per)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    per_d     = per_q;
    coil_d    = coil_q;
    tick_d    = 1'b0;
    phase_nxt = dir ? (phase_q + 2'd1) : (phase_q - 2'd1);

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        coil_d = en ? phase_pat(phase_q) : 4'b0000;
        if (en && spd_valid(speed_in)) begin
          state_d = ST_RUN;
          per_d   = lut_per;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // Partial step is dropped; phase is kept so re-enable resumes at the same coil pattern.
          state_d = ST_IDLE;
          cnt_d   = '0;
          coil_d  = 4'b0000;
        end else if (cnt_q == per_q - CNT_W'(1)) begin
          phase_d = phase_nxt;
          cnt_d   = '0;
          tick_d  = 1'b1;
          coil_d  = phase_pat(phase_nxt);
          if (spd_valid(speed_in)) per_d = lut_per;
          else                     state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          coil_d = phase_pat(phase_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      per_q   <= '0;
      coil_q  <= 4'b0000;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      coil_q  <= coil_d;
      tick_q  <= tick_d;
    end
  end

  assign coil_out  = coil_q;
  assign step_tick = tick_q;
  assign running   = (state_q == ST_RUN);

endmodule
